aes_core_seq: RTL
=================

AES_CORE_SEQ -- requirements
Module: aes_core_seq

Interface
REQ-001 Parameter LATENCY, default 11, cycles from the core_enable pulse to the cycle where core_out is valid; legal range 1..63.
REQ-002 Parameter KEY_GAP, default 1, idle cycles between the core_fsm_en pulse and the core_enable pulse; legal range 0..7.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 s_valid  input  1  request valid.
REQ-006 s_ready  output  1  sequencer accepts a request.
REQ-007 s_data  input  128  plaintext (encrypt) or ciphertext (decrypt).
REQ-008 s_key  input  128  cipher key.
REQ-009 s_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-010 core_fsm_en  output  1  one-cycle key-schedule start pulse to the selected core.
REQ-011 core_enable  output  1  one-cycle data-issue pulse to the selected core.
REQ-012 core_sel  output  1  0 = drive AES_enc, 1 = drive AES_dec.
REQ-013 core_in  output  128  data to the core's IN.
REQ-014 core_key  output  128  key to the core's KEY.
REQ-015 core_out  input  128  the selected core's OUT.
REQ-016 m_valid  output  1  result valid.
REQ-017 m_ready  input  1  downstream accepts the result.
REQ-018 m_data  output  128  captured result.

Function
REQ-019 A handshake occurs when s_valid and s_ready are both 1 on a rising edge; s_ready is 1 only in IDLE; the sequencer allows one request in flight at a time.
REQ-020 On the handshake, s_data, s_key and s_mode are registered into core_in, core_key and core_sel; these stay stable until the sequencer returns to IDLE.
REQ-021 The state machine has the states IDLE, KEYLOAD, KEYGAP, ISSUE, WAIT and HOLD.
REQ-022 IDLE -> KEYLOAD on a handshake when a key load is required (see REQ-032/033); otherwise IDLE -> ISSUE.
REQ-023 KEYLOAD lasts one cycle with core_fsm_en = 1, then moves to KEYGAP, or directly to ISSUE when KEY_GAP = 0.
REQ-024 KEYGAP lasts exactly KEY_GAP cycles, counted by an internal counter, then moves to ISSUE.
REQ-025 ISSUE lasts one cycle with core_enable = 1, then moves to WAIT.
REQ-026 If core_enable is high in cycle T, core_out is sampled into m_data at the end of cycle T+LATENCY, and m_valid = 1 from cycle T+LATENCY+1.
REQ-027 In HOLD, m_valid and m_data hold until m_valid and m_ready are both 1 on an edge; the sequencer then moves to IDLE, with s_ready = 1 in the next cycle.
REQ-028 core_fsm_en and core_enable are never 1 in the same cycle, and each is never high for two consecutive cycles.
REQ-029 m_ready is ignored outside HOLD; s_valid is ignored outside IDLE.
REQ-030 The request-to-result latency with a key load and m_ready tied high is 1 + KEY_GAP + 1 + LATENCY + 1 cycles from the handshake edge.

Reset
REQ-031 While rst = 0 at a rising edge, regardless of the current state, the sequencer:
- moves to IDLE;
- clears every counter;
- invalidates the key cache;
- drives s_ready = 0, m_valid = 0, core_fsm_en = 0, core_enable = 0, core_sel = 0, and core_in = core_key = m_data = 0.
In the first cycle after reset is released, s_ready = 1.

Configuration
REQ-032 With AES_SEQ_KEYCACHE_EN defined, the last-loaded key and mode are stored; a key load is skipped when the cache is valid and both s_key and s_mode match it.
REQ-033 With AES_SEQ_KEYCACHE_EN not defined, there is no cache storage and every request passes through KEYLOAD.

Verification
REQ-034 Encrypt with s_key = 000102030405060708090a0b0c0d0e0f and s_data = 00112233445566778899aabbccddeeff -> one core_fsm_en pulse, one core_enable pulse and m_data = 69c4e0d86a7b0430d8cdb78070b4c55a, with m_valid exactly at the cycle given by REQ-030.
REQ-035 Decrypt with the same key and s_data = 69c4e0d86a7b0430d8cdb78070b4c55a -> core_sel = 1 and m_data = 00112233445566778899aabbccddeeff.
REQ-036 Two back-to-back encrypts with the same key -> with the macro defined, the second request has no core_fsm_en pulse and is KEY_GAP+1 cycles faster; without the macro, both requests pulse core_fsm_en.
REQ-037 m_ready held at 0 for 20 cycles in HOLD -> m_valid and m_data stay stable, s_ready stays 0, and no core pulse occurs.
REQ-038 rst driven to 0 during WAIT, then released -> all outputs are zero during reset; the next identical request performs KEYLOAD (cache invalidated).
REQ-039 Boundary settings LATENCY = 1 and KEY_GAP = 0 -> core_enable follows core_fsm_en in the next cycle and the result is correct.

Source files
------------

// File: rtl/aes_core_seq.sv
// Sequencer that drives an external AES enc/dec core pair: key-schedule start, data issue, result capture.
// Optional key cache enabled by defining AES_SEQ_KEYCACHE_EN (skips KEYLOAD when key and mode repeat).
module aes_core_seq #(
  parameter int LATENCY = 11,
  parameter int KEY_GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [127:0] s_key,
  input  logic         s_mode,
  output logic         core_fsm_en,
  output logic         core_enable,
  output logic         core_sel,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data
);

  typedef enum logic [2:0] {IDLE, KEYLOAD, KEYGAP, ISSUE, WAIT, HOLD} state_e;

  localparam logic [5:0] LAT_M1 = 6'(LATENCY - 1);
  localparam logic [5:0] GAP_M1 = 6'(KEY_GAP - 1);

  state_e       state_q;
  logic [5:0]   cnt_q;
  logic         s_ready_q, fsm_en_q, enable_q, sel_q, m_valid_q;
  logic [127:0] in_q, key_q, m_data_q;
  logic         hs, need_load;

  assign hs = s_valid && s_ready_q && (state_q == IDLE);

`ifdef AES_SEQ_KEYCACHE_EN
  logic         cache_vld_q, cache_mode_q;
  logic [127:0] cache_key_q;

  assign need_load = !(cache_vld_q && (cache_key_q == s_key) && (cache_mode_q == s_mode));

  // Cache is filled at accept time; a reset mid-request clears it anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_vld_q  <= 1'b0;
      cache_mode_q <= 1'b0;
      cache_key_q  <= '0;
    end else if (hs && need_load) begin
      cache_vld_q  <= 1'b1;
      cache_mode_q <= s_mode;
      cache_key_q  <= s_key;
    end
  end
`else
  assign need_load = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      fsm_en_q  <= 1'b0;
      enable_q  <= 1'b0;
      sel_q     <= 1'b0;
      in_q      <= '0;
      key_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      fsm_en_q <= 1'b0;
      enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            s_ready_q <= 1'b0;
            in_q      <= s_data;
            key_q     <= s_key;
            sel_q     <= s_mode;
            if (need_load) begin
              state_q  <= KEYLOAD;
              fsm_en_q <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              enable_q <= 1'b1;
            end
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        KEYLOAD: begin
          if (KEY_GAP == 0) begin
            state_q  <= ISSUE;
            enable_q <= 1'b1;
          end else begin
            state_q <= KEYGAP;
            cnt_q   <= GAP_M1;
          end
        end
        KEYGAP: begin
          if (cnt_q == 6'd0) begin
            state_q  <= ISSUE;
            enable_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= LAT_M1;
        end
        // Counter hits zero in cycle T+LATENCY, where core_out is valid.
        WAIT: begin
          if (cnt_q == 6'd0) begin
            state_q   <= HOLD;
            m_valid_q <= 1'b1;
            m_data_q  <= core_out;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign core_fsm_en = fsm_en_q;
  assign core_enable = enable_q;
  assign core_sel    = sel_q;
  assign core_in     = in_q;
  assign core_key    = key_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;

endmodule
